// File: rtl/fp_mul_exp_ctrl.sv
// Exponent-path sequencer for the float32 multiplier: drives the shared exponent adder,
// waits for the normaliser decision, then applies bias, range and special-value rules.
module fp_mul_exp_ctrl #(
    parameter int EXP_W = 8,
    parameter int BIAS  = 127
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    output logic [EXP_W-1:0] exp_a_o,
    output logic [EXP_W-1:0] exp_b_o,
    input  logic [EXP_W:0]   exp_sum_i,
    output logic             norm_req,
    input  logic             norm_valid,
    input  logic             norm_inc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic             sign_out,
    output logic             ovf,
    output logic             unf,
    output logic             is_zero,
    output logic             is_inf,
    output logic             is_nan
);

    localparam int MAN_W = 31 - EXP_W;
    localparam int E_W   = EXP_W + 3;

    localparam logic [EXP_W-1:0] EXP_ALL1 = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic [E_W-1:0]   BIAS_E   = E_W'(BIAS);
    localparam logic [E_W-1:0]   MAX_E    = E_W'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        NORM,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        op_a_q, op_a_d;
    logic [31:0]        op_b_q, op_b_d;
    logic [EXP_W:0]     sum_q, sum_d;
    logic               in_ready_q, in_ready_d;
    logic               norm_req_q, norm_req_d;
    logic               out_valid_q, out_valid_d;
    logic [EXP_W-1:0]   exp_out_q, exp_out_d;
    logic               sign_out_q, sign_out_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               is_zero_q, is_zero_d;
    logic               is_inf_q, is_inf_d;
    logic               is_nan_q, is_nan_d;

    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   ma, mb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic               any_special;
    logic               sign_prod;
    logic [E_W-1:0]     e_unb;

    assign ea = op_a_q[30 -: EXP_W];
    assign eb = op_b_q[30 -: EXP_W];
    assign ma = op_a_q[MAN_W-1:0];
    assign mb = op_b_q[MAN_W-1:0];

    // Denormals carry exponent zero and are flushed to zero along with true zeros.
    assign a_zero = (ea == EXP_ZERO);
    assign b_zero = (eb == EXP_ZERO);
    assign a_inf  = (ea == EXP_ALL1) && (ma == '0);
    assign b_inf  = (eb == EXP_ALL1) && (mb == '0);
    assign a_nan  = (ea == EXP_ALL1) && (ma != '0);
    assign b_nan  = (eb == EXP_ALL1) && (mb != '0);

    assign any_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
    assign sign_prod   = op_a_q[31] ^ op_b_q[31];

    // Unbiased result in two's complement; the extra top bits hold the sign and headroom.
    assign e_unb = {2'b00, sum_q} - BIAS_E + {{(E_W-1){1'b0}}, norm_inc};

    assign exp_a_o   = ea;
    assign exp_b_o   = eb;
    assign in_ready  = in_ready_q;
    assign norm_req  = norm_req_q;
    assign out_valid = out_valid_q;
    assign exp_out   = exp_out_q;
    assign sign_out  = sign_out_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign is_zero   = is_zero_q;
    assign is_inf    = is_inf_q;
    assign is_nan    = is_nan_q;

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        sum_d      = sum_q;
        exp_out_d  = exp_out_q;
        sign_out_d = sign_out_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        is_zero_d  = is_zero_q;
        is_inf_d   = is_inf_q;
        is_nan_d   = is_nan_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_a_d  = op_a;
                    op_b_d  = op_b;
                    state_d = ADD;
                end
            end

            ADD: begin
                sum_d = exp_sum_i;
                if (any_special) begin
                    state_d    = DONE;
                    ovf_d      = 1'b0;
                    unf_d      = 1'b0;
                    is_zero_d  = 1'b0;
                    is_inf_d   = 1'b0;
                    is_nan_d   = 1'b0;
                    sign_out_d = sign_prod;
                    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                        is_nan_d   = 1'b1;
                        exp_out_d  = EXP_ALL1;
                        sign_out_d = 1'b0;
                    end else if (a_inf || b_inf) begin
                        is_inf_d  = 1'b1;
                        exp_out_d = EXP_ALL1;
                    end else begin
                        is_zero_d = 1'b1;
                        exp_out_d = EXP_ZERO;
                    end
                end else begin
                    state_d = NORM;
                end
            end

            NORM: begin
                if (norm_valid) begin
                    state_d    = DONE;
                    sign_out_d = sign_prod;
                    ovf_d      = 1'b0;
                    unf_d      = 1'b0;
                    is_zero_d  = 1'b0;
                    is_inf_d   = 1'b0;
                    is_nan_d   = 1'b0;
                    if (e_unb[E_W-1] || (e_unb == '0)) begin
                        unf_d     = 1'b1;
                        is_zero_d = 1'b1;
                        exp_out_d = EXP_ZERO;
                    end else if (e_unb >= MAX_E) begin
                        ovf_d     = 1'b1;
                        is_inf_d  = 1'b1;
                        exp_out_d = EXP_ALL1;
                    end else begin
                        exp_out_d = e_unb[EXP_W-1:0];
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Handshake strobes are registered from the next state so they track it exactly.
        in_ready_d  = (state_d == IDLE);
        norm_req_d  = (state_d == NORM);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b0;
            norm_req_q  <= 1'b0;
            out_valid_q <= 1'b0;
            exp_out_q   <= '0;
            sign_out_q  <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            is_zero_q   <= 1'b0;
            is_inf_q    <= 1'b0;
            is_nan_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sum_q       <= sum_d;
            in_ready_q  <= in_ready_d;
            norm_req_q  <= norm_req_d;
            out_valid_q <= out_valid_d;
            exp_out_q   <= exp_out_d;
            sign_out_q  <= sign_out_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            is_zero_q   <= is_zero_d;
            is_inf_q    <= is_inf_d;
            is_nan_q    <= is_nan_d;
        end
    end

endmodule

// File: tb/tb_fp_mul_exp_ctrl.sv
// Directed bench for fp_mul_exp_ctrl: models the exponent adder and normaliser handshake,
// and compares every result against hand-computed vectors.
module tb_fp_mul_exp_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [7:0]  exp_a_o;
    logic [7:0]  exp_b_o;
    logic [8:0]  exp_sum_i;
    logic        norm_req;
    logic        norm_valid;
    logic        norm_inc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic        sign_out;
    logic        ovf;
    logic        unf;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;

    int checkCount = 0;
    int failCount  = 0;

    fp_mul_exp_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .exp_a_o    (exp_a_o),
        .exp_b_o    (exp_b_o),
        .exp_sum_i  (exp_sum_i),
        .norm_req   (norm_req),
        .norm_valid (norm_valid),
        .norm_inc   (norm_inc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exp_out    (exp_out),
        .sign_out   (sign_out),
        .ovf        (ovf),
        .unf        (unf),
        .is_zero    (is_zero),
        .is_inf     (is_inf),
        .is_nan     (is_nan)
    );

    // Shared exponent adder stand-in
    assign exp_sum_i = {1'b0, exp_a_o} + {1'b0, exp_b_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // flags order: {ovf, unf, is_zero, is_inf, is_nan}
    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic inc, input int normDelay, input int readyDelay,
                                 input logic [7:0] expExpA, input logic [7:0] expExp,
                                 input logic expSign, input logic [4:0] expFlags,
                                 input int expLat, input int expNreq);
        int edges;
        int nreq;
        checkOutput({name, ".in_ready_start"}, 32'(in_ready), 32'd1);
        op_a       = a;
        op_b       = b;
        in_valid   = 1'b1;
        norm_inc   = inc;
        norm_valid = (normDelay == 0);
        out_ready  = 1'b0;
        tick();
        in_valid = 1'b0;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'h1234_5678;
        checkOutput({name, ".in_ready_after_accept"}, 32'(in_ready), 32'd0);
        edges = 1;
        nreq  = 0;
        while (!out_valid && edges < 30) begin
            if (norm_req) begin
                nreq++;
                norm_valid = (nreq > normDelay);
            end
            checkOutput({name, ".in_ready_busy"}, 32'(in_ready), 32'd0);
            tick();
            edges++;
        end
        norm_valid = 1'b0;
        checkOutput({name, ".latency"}, 32'(edges), 32'(expLat));
        checkOutput({name, ".norm_req_cycles"}, 32'(nreq), 32'(expNreq));
        checkOutput({name, ".exp_a_o"}, 32'(exp_a_o), 32'(expExpA));
        for (int i = 0; i <= readyDelay; i++) begin
            checkOutput({name, ".out_valid"}, 32'(out_valid), 32'd1);
            checkOutput({name, ".exp_out"}, 32'(exp_out), 32'(expExp));
            checkOutput({name, ".sign_out"}, 32'(sign_out), 32'(expSign));
            checkOutput({name, ".flags"}, 32'({ovf, unf, is_zero, is_inf, is_nan}), 32'(expFlags));
            checkOutput({name, ".norm_req_done"}, 32'(norm_req), 32'd0);
            checkOutput({name, ".in_ready_done"}, 32'(in_ready), 32'd0);
            if (i == readyDelay) out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        checkOutput({name, ".out_valid_after"}, 32'(out_valid), 32'd0);
        checkOutput({name, ".in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        op_a       = '0;
        op_b       = '0;
        norm_valid = 1'b0;
        norm_inc   = 1'b0;
        out_ready  = 1'b0;
        #2;
        checkOutput("reset.in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset.norm_req", 32'(norm_req), 32'd0);
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.outputs", 32'({exp_out, sign_out, ovf, unf, is_zero, is_inf, is_nan}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        //            name      op_a          op_b          inc nd rd  expA   exp    s     flags     lat nreq
        applyStimulus("c1",     32'h40000000, 32'h40400000, 0,  0, 0, 8'h80, 8'h81, 1'b0, 5'b00000, 3, 1);
        applyStimulus("c2",     32'h3FC00000, 32'h3FC00000, 1,  0, 0, 8'h7F, 8'h80, 1'b0, 5'b00000, 3, 1);
        applyStimulus("c2neg",  32'hBFC00000, 32'h3FC00000, 1,  0, 0, 8'h7F, 8'h80, 1'b1, 5'b00000, 3, 1);
        applyStimulus("c3ovf",  32'h7F000000, 32'h7F000000, 0,  0, 0, 8'hFE, 8'hFF, 1'b0, 5'b10010, 3, 1);
        applyStimulus("c3unf",  32'h00800000, 32'h00800000, 0,  0, 0, 8'h01, 8'h00, 1'b0, 5'b01100, 3, 1);
        applyStimulus("e254",   32'h7F000000, 32'h3F800000, 0,  0, 0, 8'hFE, 8'hFE, 1'b0, 5'b00000, 3, 1);
        applyStimulus("e255",   32'hFF000000, 32'h3F800000, 1,  0, 0, 8'hFE, 8'hFF, 1'b1, 5'b10010, 3, 1);
        applyStimulus("e1",     32'h00800000, 32'h3F800000, 0,  0, 0, 8'h01, 8'h01, 1'b0, 5'b00000, 3, 1);
        applyStimulus("e0",     32'h00800000, 32'hBF000000, 0,  0, 0, 8'h01, 8'h00, 1'b1, 5'b01100, 3, 1);
        applyStimulus("e0inc",  32'h00800000, 32'h3F000000, 1,  0, 0, 8'h01, 8'h01, 1'b0, 5'b00000, 3, 1);
        applyStimulus("c4nan",  32'h7F800000, 32'h00000000, 0,  0, 0, 8'hFF, 8'hFF, 1'b0, 5'b00001, 2, 0);
        applyStimulus("c4inf",  32'h7F800000, 32'h3F800000, 0,  0, 0, 8'hFF, 8'hFF, 1'b0, 5'b00010, 2, 0);
        applyStimulus("nansgn", 32'hFF800000, 32'h00000000, 0,  0, 0, 8'hFF, 8'hFF, 1'b0, 5'b00001, 2, 0);
        applyStimulus("qnan",   32'h7FC00000, 32'hFF800000, 0,  0, 0, 8'hFF, 8'hFF, 1'b0, 5'b00001, 2, 0);
        applyStimulus("denorm", 32'h80000001, 32'h40000000, 0,  0, 0, 8'h00, 8'h00, 1'b1, 5'b00100, 2, 0);
        applyStimulus("c5",     32'h40000000, 32'h40400000, 0,  4, 5, 8'h80, 8'h81, 1'b0, 5'b00000, 7, 5);

        // Reset while waiting on the normaliser must abort silently
        op_a       = 32'h40000000;
        op_b       = 32'h40400000;
        in_valid   = 1'b1;
        norm_valid = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("c6.norm_req_before", 32'(norm_req), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("c6.norm_req_reset", 32'(norm_req), 32'd0);
        checkOutput("c6.in_ready_reset", 32'(in_ready), 32'd0);
        norm_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("c6.out_valid_reset", 32'(out_valid), 32'd0);
            checkOutput("c6.norm_req_held", 32'(norm_req), 32'd0);
        end
        norm_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("c6.out_valid_release", 32'(out_valid), 32'd0);
        applyStimulus("c6c1", 32'h40000000, 32'h40400000, 0, 0, 0, 8'h80, 8'h81, 1'b0, 5'b00000, 3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
        $finish;
    end

endmodule
